// File: rtl/uart_block_tx.sv
// Purpose : 8N1 UART transmitter that sends a NUM_BYTES-wide word as back-to-back
//           byte frames on TxD, least-significant byte first.
// Latency : TxD drops to the start bit on the clock edge that sees the rising edge
//           of transmit; the burst lasts NUM_BYTES*10*BAUD_DIV cycles.
// Backpressure: none. busy is high for the whole burst, and requests seen while
//           busy are dropped.
// Ports   : clk      - system clock, rising edge
//           reset    - asynchronous, active-high reset
//           transmit - request level; only its rising edge seen in IDLE starts a burst
//           data     - word to send, captured only at burst start
//           TxD      - registered serial output, idles at 1
//           busy     - high from burst start until the last stop bit ends
module uart_block_tx #(
    parameter int BAUD_DIV  = 10417,
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   transmit,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   TxD,
    output logic                   busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_baud_cnt;
    logic [2:0]             r_bit_idx;
    logic [BW-1:0]          r_byte_idx;
    logic [8*NUM_BYTES-1:0] r_shift;
    logic                   r_transmit_q;
    logic                   r_txd;
    logic                   r_busy;

    state_t                 w_state_next;
    logic [CW-1:0]          w_baud_cnt_next;
    logic [2:0]             w_bit_idx_next;
    logic [BW-1:0]          w_byte_idx_next;
    logic [8*NUM_BYTES-1:0] w_shift_next;
    logic [7:0]             w_cur_byte;
    logic                   w_txd_next;
    logic                   w_start;
    logic                   w_bit_end;

    assign w_start   = (r_state == S_IDLE) && transmit && !r_transmit_q;
    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next    = S_START;
                    w_shift_next    = data;
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_byte_idx_next = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_state_next    = S_DATA;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
                        w_state_next   = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_next = '0;
                    if (r_byte_idx != BYTE_LAST) begin
                        // Next byte follows immediately: no idle gap between frames.
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        w_shift_next    = r_shift >> 8;
                        w_state_next    = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // TxD is registered from the next-state view so the line changes on the same
    // edge as the state, with no combinational path to the pin.
    assign w_cur_byte = w_shift_next[7:0];

    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_cur_byte[w_bit_idx_next];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_transmit_q <= 1'b0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_baud_cnt   <= w_baud_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_byte_idx   <= w_byte_idx_next;
            r_shift      <= w_shift_next;
            r_transmit_q <= transmit;
            r_txd        <= w_txd_next;
            r_busy       <= (w_state_next != S_IDLE);
        end
    end

    assign TxD  = r_txd;
    assign busy = r_busy;

endmodule

// File: tb/tb_uart_block_tx.sv
// Directed bench for uart_block_tx with BAUD_DIV=4 and NUM_BYTES=16.
module tb_uart_block_tx;

    localparam int BD = 4;
    localparam int NB = 16;
    localparam int BURST = NB * 10 * BD;  // 640
    localparam logic [127:0] MSG = 128'h48656c6c6f2044722e20416465656c21;

    logic         clk;
    logic         reset;
    logic         transmit;
    logic [127:0] data;
    logic         TxD;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic s_bits [0:2047];

    uart_block_tx #(.BAUD_DIV(BD), .NUM_BYTES(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .transmit (transmit),
        .data     (data),
        .TxD      (TxD),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Records TxD at every falling edge while busy is high; returns busy length.
    task automatic capture(output int bcyc);
        int waited;
        waited = 0;
        bcyc   = 0;
        while (!busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        while (busy && bcyc < 2000) begin
            s_bits[bcyc] = TxD;
            bcyc++;
            @(negedge clk);
        end
    endtask

    // Reads each data bit from the middle of its bit period.
    function automatic logic [127:0] decode();
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < NB; k++)
            for (int b = 0; b < 8; b++)
                w[8*k+b] = s_bits[k*40 + 4*(1+b) + 2];
        return w;
    endfunction

    function automatic int frame_errs();
        int e;
        e = 0;
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < 4; i++) begin
                if (s_bits[k*40 + i] !== 1'b0) e++;
                if (s_bits[k*40 + 36 + i] !== 1'b1) e++;
            end
        return e;
    endfunction

    task automatic test_reset();
        #3;
        n_checks++;
        if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", TxD); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (TxD !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_async: got TxD=%b busy=%b want 1/0", TxD, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        data = MSG;
        @(negedge clk);
        transmit = 1'b1;
        repeat (3) @(negedge clk);
        transmit = 1'b0;
        n_checks++;
        if (TxD !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_start_bit: got TxD=%b busy=%b want 0/1", TxD, busy);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_midbit_txd: got %b want 1", TxD); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_midbit_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_burst();
        int b;
        logic [127:0] w;
        data = MSG;
        transmit = 1'b1;
        fork
            capture(b);
            begin repeat (3) @(negedge clk); transmit = 1'b0; end
        join
        w = decode();
        n_checks++;
        if (b !== BURST) begin n_fail++; $display("FAIL single_busy_len: got %0d want %0d", b, BURST); end
        n_checks++;
        if (w !== MSG) begin n_fail++; $display("FAIL single_word: got %h want %h", w, MSG); end
        n_checks++;
        if (w[7:0] !== 8'h21) begin n_fail++; $display("FAIL single_first_byte: got %h want 21", w[7:0]); end
        n_checks++;
        if (w[127:120] !== 8'h48) begin n_fail++; $display("FAIL single_last_byte: got %h want 48", w[127:120]); end
        n_checks++;
        if (frame_errs() !== 0) begin n_fail++; $display("FAIL single_framing: got %0d bad samples want 0", frame_errs()); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame_timing();
        int b;
        logic [39:0] pat;
        data = 128'h55;
        transmit = 1'b1;
        fork
            capture(b);
            begin repeat (2) @(negedge clk); transmit = 1'b0; end
        join
        for (int i = 0; i < 40; i++) pat[39-i] = s_bits[i];
        n_checks++;
        if (pat !== 40'h0F0F0F0F0F) begin n_fail++; $display("FAIL frame_pattern: got %h want 0f0f0f0f0f", pat); end
        n_checks++;
        if (decode() !== 128'h55) begin n_fail++; $display("FAIL frame_word: got %h want 55", decode()); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_hold_high();
        int b;
        int extra;
        data = MSG;
        transmit = 1'b1;
        capture(b);
        extra = 0;
        for (int i = 0; i < 1000 - BURST; i++) begin
            if (busy !== 1'b0) extra++;
            @(negedge clk);
        end
        transmit = 1'b0;
        n_checks++;
        if (b !== BURST) begin n_fail++; $display("FAIL hold_busy_len: got %0d want %0d", b, BURST); end
        n_checks++;
        if (decode() !== MSG) begin n_fail++; $display("FAIL hold_word: got %h want %h", decode(), MSG); end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL hold_retrigger: got %0d busy cycles want 0", extra); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_toggle_midburst();
        int b;
        int extra;
        data = MSG;
        transmit = 1'b1;
        fork
            capture(b);
            begin
                repeat (3) @(negedge clk);   transmit = 1'b0;
                repeat (150) @(negedge clk); transmit = 1'b1;
                repeat (5) @(negedge clk);   transmit = 1'b0;
                repeat (100) @(negedge clk); transmit = 1'b1;
                repeat (3) @(negedge clk);   transmit = 1'b0;
            end
        join
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b0) extra++;
            @(negedge clk);
        end
        n_checks++;
        if (b !== BURST) begin n_fail++; $display("FAIL toggle_busy_len: got %0d want %0d", b, BURST); end
        n_checks++;
        if (decode() !== MSG || frame_errs() !== 0) begin
            n_fail++; $display("FAIL toggle_word: got %h (%0d frame errs) want %h", decode(), frame_errs(), MSG);
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL toggle_second_burst: got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int b1;
        int b2;
        logic [127:0] w1;
        data = MSG;
        transmit = 1'b1;
        fork
            capture(b1);
            begin repeat (3) @(negedge clk); transmit = 1'b0; end
        join
        w1 = decode();
        transmit = 1'b1;
        fork
            capture(b2);
            begin repeat (3) @(negedge clk); transmit = 1'b0; end
        join
        n_checks++;
        if (w1 !== MSG) begin n_fail++; $display("FAIL b2b_first_word: got %h want %h", w1, MSG); end
        n_checks++;
        if (decode() !== MSG) begin n_fail++; $display("FAIL b2b_second_word: got %h want %h", decode(), MSG); end
        n_checks++;
        if (b2 !== BURST) begin n_fail++; $display("FAIL b2b_second_len: got %0d want %0d", b2, BURST); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_data_stability();
        int b;
        data = MSG;
        transmit = 1'b1;
        fork
            capture(b);
            begin
                @(negedge clk); data = '0;
                repeat (2) @(negedge clk); transmit = 1'b0;
            end
        join
        n_checks++;
        if (decode() !== MSG) begin n_fail++; $display("FAIL stability_word: got %h want %h", decode(), MSG); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int b;
        int bad;
        data = MSG;
        transmit = 1'b1;
        repeat (3) @(negedge clk);
        transmit = 1'b0;
        repeat (210) @(negedge clk);   // inside byte 5
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (TxD !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midburst_reset_async: got TxD=%b busy=%b want 1/0", TxD, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midburst_idle_after: got %0d active cycles want 0", bad); end
        transmit = 1'b1;
        fork
            capture(b);
            begin repeat (3) @(negedge clk); transmit = 1'b0; end
        join
        n_checks++;
        if (b !== BURST) begin n_fail++; $display("FAIL midburst_new_len: got %0d want %0d", b, BURST); end
        n_checks++;
        if (decode() !== MSG) begin n_fail++; $display("FAIL midburst_new_word: got %h want %h", decode(), MSG); end
    endtask

    initial begin
        reset    = 1'b1;
        transmit = 1'b0;
        data     = '0;
        test_reset();
        test_single_burst();
        test_frame_timing();
        test_hold_high();
        test_toggle_midburst();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
